aes_round_key_ctrl: RTL

Sequences the AES-128 key expansion engine from a single key-load request, captures all 11 round keys into a local key store, then arbitrates round-key reads between the encrypt and decrypt cores. It sits between the key-input interface and both cipher datapaths. Neither cipher core touches the expansion engine directly.

---
 rtl/aes_pkg.sv | 8 +
 rtl/aes_round_key_ctrl_if.sv | 24 ++
 rtl/aes_rk_arbiter.sv | 22 ++
 rtl/aes_round_key_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES round-key controller types and constants
// Holds the controller state enum, round-key count, round index width and round-key type.
package aes_pkg;
  localparam int AES128_NUM_RK = 11;
  localparam int AES_RK_IDX_W = 4;
  typedef logic [127:0] aes_rk_t;
  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, READY} aes_state_e;
endpackage

// File: rtl/aes_round_key_ctrl_if.sv
// aes_round_key_ctrl_if: round-key read bus between the cipher cores and the key controller
// master: cores drive enc/dec req+round, receive grants and the registered rk_* response.
// slave: key controller side.
interface aes_round_key_ctrl_if #(parameter int KEY_W = 128);
  import aes_pkg::*;
  logic enc_req;
  logic dec_req;
  logic [AES_RK_IDX_W-1:0] enc_round;
  logic [AES_RK_IDX_W-1:0] dec_round;
  logic enc_gnt;
  logic dec_gnt;
  logic rk_valid;
  logic rk_owner;
  logic rk_err;
  logic [KEY_W-1:0] rk_data;
  modport master (
    output enc_req, enc_round, dec_req, dec_round,
    input  enc_gnt, dec_gnt, rk_valid, rk_owner, rk_err, rk_data
  );
  modport slave (
    input  enc_req, enc_round, dec_req, dec_round,
    output enc_gnt, dec_gnt, rk_valid, rk_owner, rk_err, rk_data
  );
endinterface

// File: rtl/aes_rk_arbiter.sv
// aes_rk_arbiter: two-requester round-robin arbiter for round-key reads
// Ports: clk, reset_n (async active-low), enc_req/dec_req in, grant_en in, enc_gnt/dec_gnt out.
module aes_rk_arbiter (
  input  logic clk,
  input  logic reset_n,
  input  logic enc_req,
  input  logic dec_req,
  input  logic grant_en,
  output logic enc_gnt,
  output logic dec_gnt
);
  // last_enc_q set means enc won most recently, so dec wins the next tie; reset favours enc
  logic last_enc_q, last_enc_d;
  always_comb begin
    dec_gnt = grant_en && dec_req && (!enc_req || last_enc_q);
    enc_gnt = grant_en && enc_req && !dec_gnt;
    last_enc_d = enc_gnt ? 1'b1 : dec_gnt ? 1'b0 : last_enc_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) last_enc_q <= 1'b0;
    else last_enc_q <= last_enc_d;
endmodule

// File: rtl/aes_round_key_ctrl.sv
// aes_round_key_ctrl: sequences AES-128 key expansion into a local store and serves round-key reads
// Ports: clk, reset_n (async active-low); key_load/key_in request a new schedule; key_busy/key_valid
// status; ke_start/ke_short_key drive the expansion engine, ke_subkey/ke_rdy come back from it;
// rd (slave modport) carries enc/dec read requests, grants and the registered round-key response.
// Optional macro AES_KEY_ZEROIZE_EN adds key_clear, which wipes the store and key and returns to IDLE.
module aes_round_key_ctrl
  import aes_pkg::*;
#(
  parameter int KEY_W = 128,
  parameter int NUM_RK = AES128_NUM_RK
) (
  input  logic clk,
  input  logic reset_n,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic key_clear,
`endif
  input  logic key_load,
  input  logic [KEY_W-1:0] key_in,
  output logic key_busy,
  output logic key_valid,
  output logic ke_start,
  output logic [KEY_W-1:0] ke_short_key,
  input  logic [KEY_W-1:0] ke_subkey,
  input  logic ke_rdy,
  aes_round_key_ctrl_if.slave rd
);
  localparam logic [AES_RK_IDX_W-1:0] LAST_RK = AES_RK_IDX_W'(NUM_RK - 1);
  aes_state_e state_q, state_d;
  logic [AES_RK_IDX_W-1:0] rc_q, rc_d, rd_idx;
  logic [KEY_W-1:0] key_q, key_d, rk_data_q, rk_data_d;
  logic [KEY_W-1:0] store_q [NUM_RK];
  logic [KEY_W-1:0] store_d [NUM_RK];
  logic rk_valid_q, rk_valid_d, rk_owner_q, rk_owner_d, rk_err_q, rk_err_d;
  logic grant_en, rd_bad;
  always_comb begin
    state_d = state_q;
    rc_d = rc_q;
    key_d = key_q;
    store_d = store_q;
    case (state_q)
      IDLE, READY: if (key_load) begin
        key_d = key_in;
        state_d = LOAD;
      end
      LOAD: begin
        store_d[0] = ke_subkey;
        rc_d = AES_RK_IDX_W'(1);
        state_d = EXPAND;
      end
      EXPAND: if (ke_rdy) begin
        store_d[rc_q] = ke_subkey;
        rc_d = rc_q + AES_RK_IDX_W'(1);
        if (rc_q == LAST_RK) state_d = READY;
      end
      default: state_d = IDLE;
    endcase
`ifdef AES_KEY_ZEROIZE_EN
    if (key_clear) begin
      state_d = IDLE;
      rc_d = '0;
      key_d = '0;
      store_d = '{default: '0};
    end
`endif
  end
  assign key_busy = (state_q == LOAD) || (state_q == EXPAND);
  assign key_valid = state_q == READY;
  assign ke_start = state_q == LOAD;
  assign ke_short_key = key_q;
  // a same-cycle reload (or wipe) pre-empts any read grant
`ifdef AES_KEY_ZEROIZE_EN
  assign grant_en = (state_q == READY) && !key_load && !key_clear;
`else
  assign grant_en = (state_q == READY) && !key_load;
`endif
  aes_rk_arbiter u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .enc_req (rd.enc_req),
    .dec_req (rd.dec_req),
    .grant_en(grant_en),
    .enc_gnt (rd.enc_gnt),
    .dec_gnt (rd.dec_gnt)
  );
  always_comb begin
    rd_idx = rd.dec_gnt ? rd.dec_round : rd.enc_round;
    rd_bad = rd_idx > LAST_RK;
    rk_valid_d = rd.enc_gnt || rd.dec_gnt;
    rk_owner_d = rd.dec_gnt;
    rk_err_d = rk_valid_d && rd_bad;
    rk_data_d = (rk_valid_d && !rd_bad) ? store_q[rd_idx] : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      rc_q <= '0;
      key_q <= '0;
      store_q <= '{default: '0};
      rk_valid_q <= 1'b0;
      rk_owner_q <= 1'b0;
      rk_err_q <= 1'b0;
      rk_data_q <= '0;
    end else begin
      state_q <= state_d;
      rc_q <= rc_d;
      key_q <= key_d;
      store_q <= store_d;
      rk_valid_q <= rk_valid_d;
      rk_owner_q <= rk_owner_d;
      rk_err_q <= rk_err_d;
      rk_data_q <= rk_data_d;
    end
  assign rd.rk_valid = rk_valid_q;
  assign rd.rk_owner = rk_owner_q;
  assign rd.rk_err = rk_err_q;
  assign rd.rk_data = rk_data_q;
endmodule
